vga_fb_sink: RTL and testbench
==============================

Name: vga_fb_sink

Overview:
- Receiving end of the pixel-plot interface driven by the drawing engines (vga_x, vga_y, vga_colour, vga_plot).
- Captures each plot into an on-chip 160x120x3 framebuffer, clips off-screen pixels, and counts accepted and rejected plots.
- Provides a start/done screen-clear engine and a registered read port for scan-out or bench readback.
- Sits between the drawing FSMs and the VGA scan/readback logic.

Parameters:
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.
- CNT_W, 16, width of the plot/reject counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- vga_x  in  8  plot x coordinate.
- vga_y  in  7  plot y coordinate.
- vga_colour  in  3  plot colour.
- vga_plot  in  1  plot strobe; one pixel per cycle while high.
- clear_start  in  1  level request to fill the screen with clear_colour.
- clear_colour  in  3  fill colour; sampled on the cycle clear is accepted.
- clear_done  out  1  clear complete; held while clear_start stays high.
- busy  out  1  high while a clear is in progress.
- rd_x  in  8  read x.
- rd_y  in  7  read y.
- rd_colour  out  3  pixel at (rd_x, rd_y), 1-cycle latency.
- plot_count  out  CNT_W  accepted plot writes.
- reject_count  out  CNT_W  plots clipped or dropped.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, clear_done=0, plot_count=0, reject_count=0, rd_colour=0, clear address=0. RAM contents are not reset.
- Address mapping: addr = y*160 + x, computed as (y<<7)+(y<<5)+x, 15 bits wide, range 0..19199.
- Plot path:
  - Sampled at the rising edge with vga_plot=1.
  - In IDLE or DONE with x<160 and y<120: RAM write at that edge; plot_count+1.
  - Clip case, x>=160 or y>=120: no write; reject_count+1.
  - In CLEAR: plot is dropped, no write; reject_count+1.
  - Both counters saturate at all-ones.
- Read path:
  - rd_colour is registered; the address presented in cycle N gives data in cycle N+1.
  - Read and write to the same address on the same edge returns the old data.
  - A plotted pixel is therefore readable with rd_colour valid 2 edges after the plot edge.
  - Out-of-range rd_x/rd_y returns 0.
- FSM states:
  - IDLE:
    - clear_start=1 -> CLEAR; latch clear_colour; clear address=0; busy=1.
  - CLEAR:
    - Writes the latched colour to one address per cycle, 0..19199, taking 19200 cycles.
    - A plot on the same cycle never contends for the write port, since plots are dropped in this state.
    - After writing address 19199 -> DONE; busy=0, clear_done=1.
    - clear_start deasserting mid-clear does not abort the clear.
  - DONE:
    - clear_done=1 while clear_start=1; plots accepted normally.
    - clear_start=0 -> IDLE with clear_done=0 on the next edge.
- clear_start held high after DONE does not retrigger; it must drop to 0 first. clear_start is ignored while in CLEAR.
- Reset mid-clear: returns to IDLE immediately. The partially cleared RAM keeps its contents.

Decomposition:
- Package vga_fb_pkg:
  - SCREEN_W, SCREEN_H, FB_DEPTH=19200, FB_AW=15.
  - colour_t (logic [2:0]).
  - State enum fb_state_t {IDLE, CLEAR, DONE}.
  - Function xy_to_addr().
- One sub-module, fb_ram_sdp: simple dual-port RAM, 1 write port and 1 registered read port, read-old-on-collision, no reset.
- Top level holds the FSM, clip logic, counters and write-port mux.

Test Plan:
1. Reset, then clear_start=1 with clear_colour=3'b000 -> busy high for exactly 19200 cycles, clear_done=1 afterwards; reads of (0,0), (159,119) and (80,60) return 000.
2. After clear, plot (30,20) with colour 010 for one cycle -> plot_count=1; rd (30,20) gives 010 two edges after the plot; neighbour (31,20) still reads 000.
3. Back-to-back plots on consecutive cycles: (159,119)=111, (160,0)=101, (0,120)=011 -> only (159,119) is written; plot_count+1, reject_count+2.
4. During a clear with colour 100, plot (10,10)=001 at cycle 50 -> reject_count+1; after done, (10,10) reads 100.
5. Hold clear_start high after done for 10 cycles -> clear_done stays 1 and no new clear starts. Drop clear_start -> clear_done=0 next edge; reassert -> new clear begins.
6. Assert rst_n=0 at cycle 5000 of a clear -> busy=0 and counters=0 immediately; a new clear_start after release starts again at address 0 and runs the full 19200 cycles.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared constants, types and address helper for the pixel-plot framebuffer sink.
package vga_fb_pkg;

  localparam logic [7:0]  SCREEN_W = 8'd160;
  localparam logic [6:0]  SCREEN_H = 7'd120;
  localparam int          FB_DEPTH = 19200;
  localparam int          FB_AW    = 15;
  localparam logic [14:0] FB_LAST  = 15'd19199;

  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } fb_state_t;

  // y*160 + x built from shifts so no multiplier is inferred
  function automatic logic [FB_AW-1:0] xy_to_addr(input logic [6:0] y, input logic [7:0] x);
    logic [FB_AW-1:0] y_ext;
    y_ext = {8'd0, y};
    return (y_ext << 7) + (y_ext << 5) + {7'd0, x};
  endfunction

endpackage

// File: rtl/fb_ram_sdp.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port.
// A same-edge read and write of one address returns the previous contents.
module fb_ram_sdp
  import vga_fb_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [FB_AW-1:0] waddr,
  input  colour_t          wdata,
  input  logic [FB_AW-1:0] raddr,
  output colour_t          rdata
);

  colour_t mem [FB_DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read; non-blocking update gives read-old on collision
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_fb_sink.sv
// Framebuffer sink for the drawing engines: clips and stores plots, counts
// accepted/rejected plots, runs a full-screen clear and serves a read port.
//
// state | meaning
// IDLE  | plots accepted, waiting for clear_start
// CLEAR | writing latched colour to every address, plots dropped
// DONE  | clear finished, clear_done held until clear_start drops
module vga_fb_sink
  import vga_fb_pkg::*;
#(
  parameter logic [7:0] SCREEN_W = vga_fb_pkg::SCREEN_W,
  parameter logic [6:0] SCREEN_H = vga_fb_pkg::SCREEN_H,
  parameter int         CNT_W    = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       vga_x,
  input  logic [6:0]       vga_y,
  input  logic [2:0]       vga_colour,
  input  logic             vga_plot,
  input  logic             clear_start,
  input  logic [2:0]       clear_colour,
  output logic             clear_done,
  output logic             busy,
  input  logic [7:0]       rd_x,
  input  logic [6:0]       rd_y,
  output logic [2:0]       rd_colour,
  output logic [CNT_W-1:0] plot_count,
  output logic [CNT_W-1:0] reject_count
);

  fb_state_t        state;
  colour_t          clr_colour;
  logic [FB_AW-1:0] clr_addr;

  logic             plot_in_range;
  logic             plot_ok;
  logic             plot_rej;
  logic             rd_in_range;
  logic             rd_valid;
  logic [FB_AW-1:0] rd_addr;
  colour_t          ram_q;

  logic             we;
  logic [FB_AW-1:0] waddr;
  colour_t          wdata;

  assign plot_in_range = (vga_x < SCREEN_W) && (vga_y < SCREEN_H);
  assign plot_ok       = vga_plot && plot_in_range && (state != CLEAR);
  assign plot_rej      = vga_plot && !plot_ok;

  // off-screen reads are steered to address 0 and masked on output
  assign rd_in_range   = (rd_x < SCREEN_W) && (rd_y < SCREEN_H);
  assign rd_addr       = rd_in_range ? xy_to_addr(rd_y, rd_x) : '0;

  // write-port mux: the clear engine owns the port while clearing
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (state == CLEAR) begin
      we    = 1'b1;
      waddr = clr_addr;
      wdata = clr_colour;
    end else if (plot_ok) begin
      we    = 1'b1;
      waddr = xy_to_addr(vga_y, vga_x);
      wdata = vga_colour;
    end
  end

  fb_ram_sdp u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // remember whether the read in flight was on-screen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= rd_in_range;
  end

  assign rd_colour = rd_valid ? ram_q : '0;

  // clear sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      clr_addr   <= '0;
      clr_colour <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            clr_colour <= clear_colour;
            clr_addr   <= '0;
            busy       <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_addr == FB_LAST) begin
            state      <= DONE;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        DONE: begin
          if (!clear_start) begin
            state      <= IDLE;
            clear_done <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          clear_done <= 1'b0;
        end
      endcase
    end
  end

  // saturating plot/reject counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plot_count   <= '0;
      reject_count <= '0;
    end else begin
      if (plot_ok && plot_count != '1)    plot_count   <= plot_count + 1'b1;
      if (plot_rej && reject_count != '1) reject_count <= reject_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_fb_sink.sv
// Directed bench for vga_fb_sink: clear timing, plot/clip/drop counting,
// read latency and reset-during-clear behaviour.
module tb_vga_fb_sink;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        clear_start;
  logic [2:0]  clear_colour;
  logic        clear_done;
  logic        busy;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic [2:0]  rd_colour;
  logic [15:0] plot_count;
  logic [15:0] reject_count;

  int errors = 0;
  int checks = 0;
  int exp_plot = 0;
  int exp_rej = 0;

  always #5 clk = ~clk;

  vga_fb_sink #(.CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .clear_done   (clear_done),
    .busy         (busy),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .rd_colour    (rd_colour),
    .plot_count   (plot_count),
    .reject_count (reject_count)
  );

  // one rising edge, then settle at the falling edge for sampling/driving
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [7:0] x, input logic [6:0] y);
    rd_x = x;
    rd_y = y;
    tick();
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 25000) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", clear_done); end
    checks++; if (plot_count !== 16'd0) begin errors++; $display("FAIL reset_plot_count: got %0d expected 0", plot_count); end
    checks++; if (reject_count !== 16'd0) begin errors++; $display("FAIL reset_reject_count: got %0d expected 0", reject_count); end
    checks++; if (rd_colour !== 3'd0) begin errors++; $display("FAIL reset_rd_colour: got %0h expected 0", rd_colour); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clear_black();
    int n;
    clear_colour = 3'b000;
    clear_start  = 1'b1;
    tick();
    wait_busy(n);
    checks++; if (n != 19200) begin errors++; $display("FAIL clear_cycles: got %0d expected 19200", n); end
    checks++; if (clear_done !== 1'b1) begin errors++; $display("FAIL clear_done_set: got %0b expected 1", clear_done); end
    clear_start = 1'b0;
    do_read(8'd0, 7'd0);
    checks++; if (rd_colour !== 3'b000) begin errors++; $display("FAIL clear_rd_0_0: got %0h expected 0", rd_colour); end
    do_read(8'd159, 7'd119);
    checks++; if (rd_colour !== 3'b000) begin errors++; $display("FAIL clear_rd_159_119: got %0h expected 0", rd_colour); end
    do_read(8'd80, 7'd60);
    checks++; if (rd_colour !== 3'b000) begin errors++; $display("FAIL clear_rd_80_60: got %0h expected 0", rd_colour); end
  endtask

  task automatic test_plot();
    vga_x = 8'd30; vga_y = 7'd20; vga_colour = 3'b010; vga_plot = 1'b1;
    rd_x = 8'd30; rd_y = 7'd20;
    tick();
    vga_plot = 1'b0;
    exp_plot++;
    checks++; if (rd_colour !== 3'b000) begin errors++; $display("FAIL plot_read_old: got %0h expected 0", rd_colour); end
    tick();
    checks++; if (rd_colour !== 3'b010) begin errors++; $display("FAIL plot_read_new: got %0h expected 2", rd_colour); end
    checks++; if (plot_count !== 16'(exp_plot)) begin errors++; $display("FAIL plot_count_1: got %0d expected %0d", plot_count, exp_plot); end
    do_read(8'd31, 7'd20);
    checks++; if (rd_colour !== 3'b000) begin errors++; $display("FAIL plot_neighbour: got %0h expected 0", rd_colour); end
  endtask

  task automatic test_back_to_back();
    vga_plot = 1'b1;
    vga_x = 8'd159; vga_y = 7'd119; vga_colour = 3'b111; tick();
    vga_x = 8'd160; vga_y = 7'd0;   vga_colour = 3'b101; tick();
    vga_x = 8'd0;   vga_y = 7'd120; vga_colour = 3'b011; tick();
    vga_plot = 1'b0;
    exp_plot += 1;
    exp_rej  += 2;
    checks++; if (plot_count !== 16'(exp_plot)) begin errors++; $display("FAIL b2b_plot_count: got %0d expected %0d", plot_count, exp_plot); end
    checks++; if (reject_count !== 16'(exp_rej)) begin errors++; $display("FAIL b2b_reject_count: got %0d expected %0d", reject_count, exp_rej); end
    do_read(8'd159, 7'd119);
    checks++; if (rd_colour !== 3'b111) begin errors++; $display("FAIL b2b_rd_corner: got %0h expected 7", rd_colour); end
    do_read(8'd160, 7'd0);
    checks++; if (rd_colour !== 3'b000) begin errors++; $display("FAIL b2b_rd_offscreen: got %0h expected 0", rd_colour); end
    do_read(8'd0, 7'd0);
    checks++; if (rd_colour !== 3'b000) begin errors++; $display("FAIL b2b_rd_origin: got %0h expected 0", rd_colour); end
  endtask

  task automatic test_clear_with_plot();
    int n;
    clear_colour = 3'b100;
    clear_start  = 1'b1;
    tick();
    vga_x = 8'd10; vga_y = 7'd10; vga_colour = 3'b001;
    n = 0;
    while (busy && n < 25000) begin
      vga_plot = (n == 50);
      n++;
      tick();
    end
    vga_plot = 1'b0;
    exp_rej++;
    checks++; if (n != 19200) begin errors++; $display("FAIL clr2_cycles: got %0d expected 19200", n); end
    checks++; if (reject_count !== 16'(exp_rej)) begin errors++; $display("FAIL clr2_reject_count: got %0d expected %0d", reject_count, exp_rej); end
    checks++; if (plot_count !== 16'(exp_plot)) begin errors++; $display("FAIL clr2_plot_count: got %0d expected %0d", plot_count, exp_plot); end
    do_read(8'd10, 7'd10);
    checks++; if (rd_colour !== 3'b100) begin errors++; $display("FAIL clr2_rd_10_10: got %0h expected 4", rd_colour); end
    do_read(8'd30, 7'd20);
    checks++; if (rd_colour !== 3'b100) begin errors++; $display("FAIL clr2_rd_30_20: got %0h expected 4", rd_colour); end
  endtask

  task automatic test_hold_done();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || clear_done !== 1'b1) begin
        errors++;
        $display("FAIL hold_done[%0d]: got busy=%0b done=%0b expected busy=0 done=1", i, busy, clear_done);
      end
    end
    clear_start = 1'b0;
    tick();
    checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL done_drop: got %0b expected 0", clear_done); end
    clear_colour = 3'b001;
    clear_start  = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL retrigger_busy: got %0b expected 1", busy); end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    // busy already high: 5000 more edges write addresses 0..4999 with 001
    for (int i = 0; i < 5000; i++) tick();
    clear_start = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_plot = 0;
    exp_rej  = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
    checks++; if (plot_count !== 16'd0) begin errors++; $display("FAIL rstmid_plot_count: got %0d expected 0", plot_count); end
    checks++; if (reject_count !== 16'd0) begin errors++; $display("FAIL rstmid_reject_count: got %0d expected 0", reject_count); end
    @(negedge clk);
    rst_n = 1'b1;
    do_read(8'd0, 7'd0);
    checks++; if (rd_colour !== 3'b001) begin errors++; $display("FAIL rstmid_partial_lo: got %0h expected 1", rd_colour); end
    do_read(8'd80, 7'd60);
    checks++; if (rd_colour !== 3'b100) begin errors++; $display("FAIL rstmid_partial_hi: got %0h expected 4", rd_colour); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %0b expected 0", busy); end
    clear_colour = 3'b110;
    clear_start  = 1'b1;
    tick();
    wait_busy(n);
    checks++; if (n != 19200) begin errors++; $display("FAIL rstmid_full_clear: got %0d expected 19200", n); end
    clear_start = 1'b0;
    do_read(8'd0, 7'd0);
    checks++; if (rd_colour !== 3'b110) begin errors++; $display("FAIL rstmid_rd_first: got %0h expected 6", rd_colour); end
    do_read(8'd159, 7'd119);
    checks++; if (rd_colour !== 3'b110) begin errors++; $display("FAIL rstmid_rd_last: got %0h expected 6", rd_colour); end
  endtask

  initial begin
    rst_n        = 1'b0;
    vga_x        = '0;
    vga_y        = '0;
    vga_colour   = '0;
    vga_plot     = 1'b0;
    clear_start  = 1'b0;
    clear_colour = '0;
    rd_x         = '0;
    rd_y         = '0;
    @(negedge clk);
    test_reset();
    test_clear_black();
    test_plot();
    test_back_to_back();
    test_clear_with_plot();
    test_hold_done();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
